// File: rtl/onchip_mem_stream_pkg.sv
// onchip_mem_stream_pkg: shared CSR map, status bits and FSM encoding for the RAM stream reader
package onchip_mem_stream_pkg;
   localparam logic [1:0] CSR_START   = 2'd0;
   localparam logic [1:0] CSR_LENGTH  = 2'd1;
   localparam logic [1:0] CSR_CONTROL = 2'd2;
   localparam logic [1:0] CSR_STATUS  = 2'd3;
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ABORTED = 2;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/stream_skid_fifo2.sv
// stream_skid_fifo2: 2-entry FIFO with simultaneous push/pop and synchronous flush
module stream_skid_fifo2 #(
   parameter int W = 34
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic [1:0]   count
);
   logic [W-1:0] mem [2];
   logic wp, rp, do_push, do_pop;
   always_comb begin
      do_pop  = pop & (count != 2'd0);
      do_push = push & ((count != 2'd2) | do_pop);
      empty   = count == 2'd0;
      dout    = mem[rp];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wp    <= 1'b0;
         rp    <= 1'b0;
         count <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wp] <= din;
            wp      <= ~wp;
         end
         if (do_pop) rp <= ~rp;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader: CSR-programmed sequential RAM reader emitting one Avalon-ST packet
module onchip_mem_stream_reader #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        csr_address,
   input  logic              csr_chipselect,
   input  logic              csr_write,
   input  logic              csr_read,
   input  logic [31:0]       csr_writedata,
   output logic [31:0]       csr_readdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] src_data,
   output logic              src_valid,
   input  logic              src_ready,
   output logic              src_startofpacket,
   output logic              src_endofpacket
);
   import onchip_mem_stream_pkg::*;
   state_t state;
   logic [ADDR_W-1:0] start_r, rd_ptr;
   logic [LEN_W-1:0] len_r, left;
   logic done, aborted, in_flight, pend_sop, pend_eop;
   logic [DATA_W+1:0] q;
   logic empty;
   logic [1:0] count;
   logic csr_wr, go, abort, pop, issue;
   logic [31:0] status, rd_val;
   always_comb begin
      csr_wr = csr_chipselect & csr_write;
      go     = csr_wr & (csr_address == CSR_CONTROL) & csr_writedata[0];
      abort  = csr_wr & (csr_address == CSR_CONTROL) & csr_writedata[1] & (state != IDLE);
      pop    = !empty & src_ready;
      // a popping beat frees its slot this cycle, which keeps a 1 word/cycle stream
      issue  = (state == RUN) & !abort &
               (({1'b0, count} + {2'b0, in_flight}) <= (3'd1 + {2'b0, pop}));
      status = '0;
      status[STAT_BUSY]    = state != IDLE;
      status[STAT_DONE]    = done;
      status[STAT_ABORTED] = aborted;
      rd_val = csr_address == CSR_START  ? 32'(start_r) :
               csr_address == CSR_LENGTH ? 32'(len_r) :
               csr_address == CSR_STATUS ? status : '0;
   end
   assign mem_address       = rd_ptr;
   assign mem_chipselect    = issue;
   assign mem_write         = 1'b0;
   assign mem_clken         = 1'b1;
   assign src_valid         = !empty;
   assign src_data          = q[DATA_W-1:0];
   assign src_endofpacket   = !empty & q[DATA_W];
   assign src_startofpacket = !empty & q[DATA_W+1];
   stream_skid_fifo2 #(.W(DATA_W + 2)) u_fifo (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (in_flight),
      .din   ({pend_sop, pend_eop, mem_readdata}),
      .pop   (pop),
      .flush (abort),
      .dout  (q),
      .empty (empty),
      .count (count)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         start_r      <= '0;
         len_r        <= '0;
         rd_ptr       <= '0;
         left         <= '0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         in_flight    <= 1'b0;
         pend_sop     <= 1'b0;
         pend_eop     <= 1'b0;
         csr_readdata <= '0;
      end else begin
         csr_readdata <= (csr_chipselect & csr_read) ? rd_val : '0;
         in_flight    <= issue;
         pend_sop     <= left == len_r;
         pend_eop     <= left == LEN_W'(1);
         if (issue) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            left   <= left - LEN_W'(1);
         end
         if (go) begin
            done    <= 1'b0;
            aborted <= 1'b0;
         end
         if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (csr_wr & (csr_address == CSR_START)) start_r <= csr_writedata[ADDR_W-1:0];
                  if (csr_wr & (csr_address == CSR_LENGTH)) len_r <= csr_writedata[LEN_W-1:0];
                  if (go) begin
                     if (len_r == '0) done <= 1'b1;
                     else begin
                        state  <= RUN;
                        rd_ptr <= start_r;
                        left   <= len_r;
                     end
                  end
               end
               RUN: if (issue && left == LEN_W'(1)) state <= DRAIN;
               DRAIN: if (pop && q[DATA_W]) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
